// File: rtl/dmem_lsu_if.sv
// Request/response bus between the core datapath (master) and the load/store unit (slave).
interface dmem_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_err, resp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_err, resp_rdata
    );
endinterface

// File: rtl/dmem_lsu.sv
// Load/store unit driving a word-only dmem with 1-cycle registered read.
// Byte/half loads are lane-selected and extended; sub-word stores use read-modify-write.
`ifndef MEM_BYTES_DMEM
`define MEM_BYTES_DMEM 4096
`endif

module dmem_lsu #(
    parameter int unsigned MEM_BYTES = `MEM_BYTES_DMEM
) (
    input  logic        clk,
    input  logic        rst_n,
    dmem_lsu_if.slave   bus,
    output logic        dmem_write_en,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_write_data,
    input  logic [31:0] dmem_read_data
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WRITE} state_t;

    localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);
    localparam logic [1:0]  SZ_BYTE   = 2'b00;
    localparam logic [1:0]  SZ_HALF   = 2'b01;
    localparam logic [1:0]  SZ_WORD   = 2'b10;

    state_t      state_reg, state_next;
    logic        we_reg, we_next;
    logic [1:0]  size_reg, size_next;
    logic        uns_reg, uns_next;
    logic [1:0]  lane_reg, lane_next;
    logic [31:0] wdata_reg, wdata_next;
    logic        resp_valid_reg, resp_valid_next;
    logic        resp_err_reg, resp_err_next;
    logic [31:0] resp_rdata_reg, resp_rdata_next;
    logic        wen_reg, wen_next;
    logic [31:0] maddr_reg, maddr_next;
    logic [31:0] mwdata_reg, mwdata_next;

    logic [31:0] req_word_addr;
    logic        req_err;
    logic [31:0] shifted_data;
    logic [31:0] load_data;
    logic [3:0]  lane_sel;
    logic [31:0] merged_data;

    assign req_word_addr = {bus.req_addr[31:2], 2'b00};

    // All illegal requests are rejected here, so dmem never sees an out-of-range address.
    assign req_err = (bus.req_size == 2'b11)
                   || ((bus.req_size == SZ_HALF) && bus.req_addr[0])
                   || ((bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00))
                   || (req_word_addr > LAST_WORD);

    // Right-justify the addressed lane; half lanes always have lane_reg[0]=0.
    assign shifted_data = dmem_read_data >> {lane_reg, 3'b000};

    always_comb begin
        load_data = dmem_read_data;
        case (size_reg)
            SZ_BYTE: load_data = {{24{~uns_reg & shifted_data[7]}}, shifted_data[7:0]};
            SZ_HALF: load_data = {{16{~uns_reg & shifted_data[15]}}, shifted_data[15:0]};
            default: load_data = dmem_read_data;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_sel[gi] = (size_reg == SZ_BYTE) ? (lane_reg == 2'(gi))
                                                        : (lane_reg[1] == 1'(gi / 2));
            assign merged_data[8*gi +: 8] =
                !lane_sel[gi]          ? dmem_read_data[8*gi +: 8] :
                (size_reg == SZ_BYTE)  ? wdata_reg[7:0]
                                       : wdata_reg[8*(gi % 2) +: 8];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            we_reg         <= 1'b0;
            size_reg       <= 2'b00;
            uns_reg        <= 1'b0;
            lane_reg       <= 2'b00;
            wdata_reg      <= 32'h0;
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            resp_rdata_reg <= 32'h0;
            wen_reg        <= 1'b0;
            maddr_reg      <= 32'h0;
            mwdata_reg     <= 32'h0;
        end else begin
            state_reg      <= state_next;
            we_reg         <= we_next;
            size_reg       <= size_next;
            uns_reg        <= uns_next;
            lane_reg       <= lane_next;
            wdata_reg      <= wdata_next;
            resp_valid_reg <= resp_valid_next;
            resp_err_reg   <= resp_err_next;
            resp_rdata_reg <= resp_rdata_next;
            wen_reg        <= wen_next;
            maddr_reg      <= maddr_next;
            mwdata_reg     <= mwdata_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        we_next         = we_reg;
        size_next       = size_reg;
        uns_next        = uns_reg;
        lane_next       = lane_reg;
        wdata_next      = wdata_reg;
        wen_next        = wen_reg;
        maddr_next      = maddr_reg;
        mwdata_next     = mwdata_reg;
        resp_valid_next = 1'b0;
        resp_err_next   = 1'b0;
        resp_rdata_next = 32'h0;

        case (state_reg)
            IDLE: begin
                if (bus.req_valid) begin
                    if (req_err) begin
                        resp_valid_next = 1'b1;
                        resp_err_next   = 1'b1;
                    end else begin
                        we_next    = bus.req_we;
                        size_next  = bus.req_size;
                        uns_next   = bus.req_unsigned;
                        lane_next  = bus.req_addr[1:0];
                        wdata_next = bus.req_wdata;
                        maddr_next = req_word_addr;
                        if (bus.req_we && (bus.req_size == SZ_WORD)) begin
                            wen_next    = 1'b1;
                            mwdata_next = bus.req_wdata;
                        end else begin
                            wen_next = 1'b0;
                        end
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (we_reg && (size_reg == SZ_WORD)) begin
                    wen_next        = 1'b0;
                    resp_valid_next = 1'b1;
                    state_next      = IDLE;
                end else begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (!we_reg) begin
                    resp_rdata_next = load_data;
                    resp_valid_next = 1'b1;
                    state_next      = IDLE;
                end else begin
                    mwdata_next = merged_data;
                    wen_next    = 1'b1;
                    state_next  = WRITE;
                end
            end
            WRITE: begin
                wen_next        = 1'b0;
                resp_valid_next = 1'b1;
                state_next      = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.req_ready   = (state_reg == IDLE);
    assign bus.resp_valid  = resp_valid_reg;
    assign bus.resp_err    = resp_err_reg;
    assign bus.resp_rdata  = resp_rdata_reg;
    assign dmem_write_en   = wen_reg;
    assign dmem_addr       = maddr_reg;
    assign dmem_write_data = mwdata_reg;

endmodule
